// File: rtl/cpu_types_pkg.sv
// Shared fetch-path types and reset vector.
// Imported by the prefetch unit and its queues.
package cpu_types_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Read data is the current head; valid when count_o != 0.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = inc(wr_q);
      if (pop_i)  rd_d = inc(rd_q);
      if (push_i && !pop_i) cnt_d = cnt_q + CW'(1);
      if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching fetch unit: sequential PC+4 requests, in-order
// responses into an instruction queue, flush on redirect.
module ifu_prefetch
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int FETCH_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] i_addr,
  output logic        i_addr_valid,
  input  logic        i_addr_ready,
  input  logic        i_rdata_valid,
  input  logic [31:0] i_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FETCH_DEPTH + 1);
  localparam logic [31:0] MAXO = 32'(MAX_OUTSTANDING);
  localparam logic [31:0] QDEP = 32'(FETCH_DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic         pend_stale_q, pend_stale_d;
  logic [CW-1:0] stale_q, stale_d;

  logic [CW-1:0] inflight;
  logic [QW-1:0] q_count;
  logic [31:0]   tag_pc;
  fetch_entry_t  head, push_ent;
  logic          issue_ok, accept, drop, live_push, pop;
  logic [31:0]   live_cnt;

  // Credits count live in-flight requests against queue space.
  assign live_cnt = 32'(inflight) - 32'(stale_q) + 32'(q_count);
  assign issue_ok = !pend_q && (32'(inflight) < MAXO)
                    && (live_cnt < QDEP);

  assign i_addr_valid = !rst && (pend_q || issue_ok);
  assign i_addr       = pend_q ? pend_addr_q : fetch_pc_q;
  assign accept       = i_addr_valid && i_addr_ready;
  assign drop         = i_rdata_valid && (stale_q != '0);
  assign live_push    = i_rdata_valid && !drop && !redirect_valid;
  assign out_valid    = (q_count != '0);
  assign pop          = out_valid && out_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_d       = i_addr_valid && !i_addr_ready;
    pend_addr_d  = i_addr;
    pend_stale_d = pend_d && (pend_stale_q || redirect_valid);
    stale_d      = stale_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target & ~32'h3;
      stale_d    = inflight + CW'(accept) - CW'(i_rdata_valid);
    end else begin
      if (accept && !pend_stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
      stale_d = stale_q - CW'(drop) + CW'(accept && pend_stale_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pend_q       <= 1'b0;
      pend_addr_q  <= RESET_PC;
      pend_stale_q <= 1'b0;
      stale_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_stale_q <= pend_stale_d;
      stale_q      <= stale_d;
    end
  end

  // Tag occupancy doubles as the in-flight counter.
  sync_fifo #(
    .WIDTH(32),
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_q (
    .clk    (clk),
    .rst    (rst),
    .flush_i(1'b0),
    .push_i (accept),
    .wdata_i(i_addr),
    .pop_i  (i_rdata_valid),
    .rdata_o(tag_pc),
    .count_o(inflight)
  );

  assign push_ent = '{pc: tag_pc, inst: i_rdata};

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FETCH_DEPTH)
  ) u_inst_q (
    .clk    (clk),
    .rst    (rst),
    .flush_i(redirect_valid),
    .push_i (live_push),
    .wdata_i(push_ent),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(q_count)
  );

  assign out_pc   = out_valid ? head.pc : '0;
  assign out_inst = out_valid ? head.inst : '0;

endmodule
